lu_serial_arbiter: RTL and testbench
====================================

# lu_serial_arbiter

Bit-serial controller that shares one 1-bit logic unit (AND/NAND/OR/NOR) between two requesters. It arbitrates round-robin between the requesters, latches the granted requester's WIDTH-bit operands and opcode, and feeds them through the 1-bit logic unit one bit per cycle, LSB first. It then presents the assembled WIDTH-bit result with a one-cycle done pulse tagged with the requester id. It sits between the 1-bit LU datapath and the blocks that need word-wide logic operations.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥2)

Ports:
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  reset, synchronous, active-high
- req0  input  1  requester 0 request
- a0, b0  input  WIDTH each  requester 0 operands
- op0  input  2  requester 0 opcode: 00 AND, 01 NAND, 10 OR, 11 NOR
- req1, a1, b1, op1  input  1/WIDTH/WIDTH/2  same for requester 1
- gnt0, gnt1  output  1  one-cycle grant pulse; operands accepted
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; result valid
- done_id  output  1  requester whose result is on result
- result  output  WIDTH  last completed result; held until next done

## Operation
- States: IDLE, RUN, DONE.
- IDLE: at each edge, sample req0/req1.
  - If neither is high, stay in IDLE.
  - Otherwise grant one requester:
    - Latch a/b/op of the winner.
    - Load bit counter with WIDTH.
    - Pulse gntN for one cycle.
    - Set busy.
    - Go to RUN.
- Arbitration: a 1-bit priority pointer selects the favored requester when both request; reset value favors requester 0. After each grant the pointer favors the other requester. A lone request always wins regardless of pointer.
- RUN: each edge computes op(a[i], b[i]) for the current bit i, LSB first. The result bit shifts into an internal shift register from the MSB side, and the counter decrements. After WIDTH RUN edges, transfer the shift register to result, set done_id, pulse done, and go to DONE.
- DONE: one cycle. On the next edge, clear busy and go to IDLE.
- Requests are ignored while in RUN or DONE.
- Requesters hold req and operands stable until they see gntN, then may change them freely.
- A req still high when IDLE next samples is a new request.
- A req that drops before it is sampled in IDLE produces no grant.
- Opcode arithmetic is pure bitwise; there are no carries. result = op(a, b) over all WIDTH bits.

## Timing
- Reset values: gnt0=gnt1=0, busy=0, done=0, done_id=0, result=0, pointer→requester 0, state IDLE, internal registers 0.
- Edge E0, IDLE sample: gntN=1 and busy=1 during cycle E0..E1.
- Edges E1..E_WIDTH: one bit each.
- After E_WIDTH: done=1 and result/done_id valid, for exactly one cycle.
- After E_WIDTH+1: done=0, busy=0, state IDLE.
- Earliest next grant sample: E_WIDTH+2. Throughput: one operation per WIDTH+2 cycles.
- Request-sample to done: WIDTH cycles.
- result changes only in the cycle done rises.
- rst high at any edge, including mid-RUN or in DONE:
  - Operation is aborted with no done pulse.
  - All outputs and the pointer return to reset values on that edge.
  - rst dominates simultaneous requests.
- gnt0 and gnt1 are never high together.
- At most one operation is in flight.

## Test plan
- Single AND: WIDTH=8, req0, a0=0xF0, b0=0xCC, op0=00 → gnt0 one cycle after sample; done 8 cycles after sample; result=0xC0, done_id=0; busy high for 9 cycles.
- NAND and NOR from requester 1:
  - a1=0xF0, b1=0xCC, op1=01 → result=0x3F, done_id=1.
  - a1=0xFF, b1=0x01, op1=11 → result=0x00.
  - a1=0x00, b1=0x00, op1=11 → result=0xFF.
- Round-robin: req0 and req1 both held high after reset → grant order 0, 1, 0, 1. With req0 (OR 0x0F|0xF0) and req1 (AND 0xAA&0x55), results alternate 0xFF/id0 and 0x00/id1.
- Busy ignore and dropped request:
  - req1 asserted during requester 0's RUN → no gnt1 until IDLE, then granted at E_WIDTH+2.
  - req0 pulsed for one cycle coinciding with a RUN cycle and then dropped → never granted.
- Reset mid-RUN: rst on the 4th RUN edge → no done pulse; outputs and result become 0; following req1, op=10, a1=0x12, b1=0x40 → result=0x52. Post-reset pointer favors requester 0 on simultaneous requests.
- Result hold: after a done, change operands and leave req low for 20 cycles → result and done_id unchanged, done stays 0.

Source files
------------

// File: rtl/lu_serial_arbiter.sv
// ============================================================================
// Module   : lu_serial_arbiter
// Brief    : Round-robin shared bit-serial AND/NAND/OR/NOR unit for two
//            requesters; LSB-first, result presented with a tagged done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lu_serial_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [1:0]       op0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic [1:0]       op1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] result
);

    localparam int         c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]         r_state;
    logic               r_ptr;
    logic               r_id;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_shift;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_pick1;
    logic               w_base;
    logic               w_bit;
    logic [WIDTH-1:0]   w_shift_next;

    // Requester 1 wins when alone, or when both request and the pointer favours it.
    assign w_pick1      = req1 & (~req0 | r_ptr);
    // op[1] picks OR vs AND; op[0] inverts for the N-variants.
    assign w_base       = r_op[1] ? (r_a[0] | r_b[0]) : (r_a[0] & r_b[0]);
    assign w_bit        = w_base ^ r_op[0];
    assign w_shift_next = {w_bit, r_shift[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_ptr   <= 1'b0;
            r_id    <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_shift <= '0;
            r_cnt   <= '0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 1'b0;
            result  <= '0;
        end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (req0 | req1) begin
                        r_a     <= w_pick1 ? a1 : a0;
                        r_b     <= w_pick1 ? b1 : b0;
                        r_op    <= w_pick1 ? op1 : op0;
                        r_id    <= w_pick1;
                        r_ptr   <= ~w_pick1;
                        gnt0    <= ~w_pick1;
                        gnt1    <= w_pick1;
                        busy    <= 1'b1;
                        r_cnt   <= c_CNT_W'(WIDTH);
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt - c_CNT_W'(1);
                    if (r_cnt == c_CNT_W'(1)) begin
                        result  <= w_shift_next;
                        done_id <= r_id;
                        done    <= 1'b1;
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lu_serial_arbiter.sv
// ============================================================================
// Module   : tb_lu_serial_arbiter
// Brief    : Directed plus randomized bench for lu_serial_arbiter against a
//            word-level reference of the logic ops and round-robin rule.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lu_serial_arbiter;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [1:0]       op0, op1;
    logic             gnt0, gnt1, busy, done, done_id;
    logic [WIDTH-1:0] result;

    int               checks = 0;
    int               errors = 0;
    bit               m_ptr;
    bit               m_id;
    logic [WIDTH-1:0] m_result;

    lu_serial_arbiter #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0), .op0(op0),
        .req1(req1), .a1(a1), .b1(b1), .op1(op1),
        .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
        .done(done), .done_id(done_id), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] lu_ref(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                                input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return ~(a & b);
            2'b10:   return a | b;
            default: return ~(a | b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_ptr    = 1'b0;
        m_id     = 1'b0;
        m_result = '0;
    endtask

    // One full transaction from the sampling edge to the return to IDLE.
    task automatic run_one(input bit hold, input int raise1_at, input int pulse0_at);
        bit               win;
        logic [WIDTH-1:0] exp;
        win   = (req0 && req1) ? m_ptr : req1;
        m_ptr = !win;
        exp   = win ? lu_ref(a1, b1, op1) : lu_ref(a0, b0, op0);
        step;
        chk("gnt0", 32'(gnt0), 32'(!win));
        chk("gnt1", 32'(gnt1), 32'(win));
        chk("busy_grant", 32'(busy), 32'd1);
        chk("done_grant", 32'(done), 32'd0);
        if (!hold) begin
            if (win) begin
                req1 = 1'b0; a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = 2'($urandom);
            end else begin
                req0 = 1'b0; a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = 2'($urandom);
            end
        end
        for (int k = 1; k < WIDTH; k++) begin
            step;
            chk("run_done", 32'(done), 32'd0);
            chk("run_busy", 32'(busy), 32'd1);
            chk("run_gnt", 32'(gnt0 | gnt1), 32'd0);
            chk("run_result_hold", 32'(result), 32'(m_result));
            if (k == raise1_at) req1 = 1'b1;
            if (k == pulse0_at) req0 = 1'b1;
            else if (k == pulse0_at + 1) req0 = 1'b0;
        end
        step;
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_busy", 32'(busy), 32'd1);
        chk("result", 32'(result), 32'(exp));
        chk("done_id", 32'(done_id), 32'(win));
        m_result = exp;
        m_id     = win;
        step;
        chk("done_clear", 32'(done), 32'd0);
        chk("busy_clear", 32'(busy), 32'd0);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_gnt"}, 32'({gnt0, gnt1}), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_result"}, 32'(result), 32'(m_result));
        chk({tag, "_id"}, 32'(done_id), 32'(m_id));
    endtask

    initial begin
        int r;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; op0 = '0; a1 = '0; b1 = '0; op1 = '0;
        model_reset();
        step; step;
        chk_quiet("reset");
        rst = 1'b0;

        // Single AND from requester 0
        a0 = 8'hF0; b0 = 8'hCC; op0 = 2'b00; req0 = 1'b1;
        run_one(1'b0, -1, -1);

        // NAND and NOR from requester 1
        a1 = 8'hF0; b1 = 8'hCC; op1 = 2'b01; req1 = 1'b1;
        run_one(1'b0, -1, -1);
        a1 = 8'hFF; b1 = 8'h01; op1 = 2'b11; req1 = 1'b1;
        run_one(1'b0, -1, -1);
        a1 = 8'h00; b1 = 8'h00; op1 = 2'b11; req1 = 1'b1;
        run_one(1'b0, -1, -1);

        // Round-robin with both requests held after reset
        rst = 1'b1; step; rst = 1'b0; model_reset();
        a0 = 8'h0F; b0 = 8'hF0; op0 = 2'b10;
        a1 = 8'hAA; b1 = 8'h55; op1 = 2'b00;
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) run_one(1'b1, -1, -1);
        req0 = 1'b0; req1 = 1'b0;

        // Request during RUN waits; a one-cycle req0 pulse in RUN is lost
        a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = 2'($urandom); req0 = 1'b1;
        a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = 2'($urandom);
        run_one(1'b0, 3, 5);
        run_one(1'b0, -1, -1);
        for (int i = 0; i < 3; i++) begin
            step;
            chk_quiet("after_drop");
        end

        // Reset on the 4th RUN edge aborts with no done
        a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = 2'($urandom); req0 = 1'b1;
        step;
        req0 = 1'b0;
        step; step; step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        model_reset();
        chk_quiet("mid_run_reset");
        step;
        chk_quiet("post_reset");
        a1 = 8'h12; b1 = 8'h40; op1 = 2'b10; req1 = 1'b1;
        run_one(1'b0, -1, -1);

        // Pointer favours requester 0 right after reset
        rst = 1'b1; step; rst = 1'b0; model_reset();
        a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = 2'($urandom);
        a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = 2'($urandom);
        req0 = 1'b1; req1 = 1'b1;
        run_one(1'b0, -1, -1);
        run_one(1'b0, -1, -1);

        // Randomized traffic
        for (int i = 0; i < 16; i++) begin
            r = int'($urandom_range(1, 3));
            a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = 2'($urandom);
            a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = 2'($urandom);
            req0 = r[0]; req1 = r[1];
            run_one(1'b0, -1, -1);
            req0 = 1'b0; req1 = 1'b0;
        end

        // Result holds while idle with changing operands
        for (int i = 0; i < 20; i++) begin
            a0 = WIDTH'($urandom); b0 = WIDTH'($urandom); op0 = 2'($urandom);
            a1 = WIDTH'($urandom); b1 = WIDTH'($urandom); op1 = 2'($urandom);
            step;
            chk_quiet("idle_hold");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
